button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Per-channel synchroniser, debouncer and edge detector for the board push-buttons.
//   Sits directly upstream of alarm_clock: raw btn[3:0] pins in; clean levels and single-cycle press/release pulses out.
//   btn_level drives the reset/STOP inputs of alarm_clock. btn_press drives the load_time/load_alarm strobes.
// PARAMETERS
//   N_BTN            4          number of button channels
//   CNT_W            20         width of debounce and repeat counters
//   DEBOUNCE_CYCLES  1000000    cycles an input must stay stable before it is accepted (10 ms @ 100 MHz)
//   HOLD_CYCLES      50000000   cycles held before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN)
//   REPEAT_CYCLES    20000000   cycles between later auto-repeat pulses (used only with BTN_AUTOREPEAT_EN)
//   REPEAT_MASK      4'b0110    channels allowed to auto-repeat (bit i = channel i)
// PORTS
//   clk          in   1      system clock; all state on the rising edge
//   reset        in   1      asynchronous, active-low reset
//   btn_in       in   N_BTN  raw asynchronous button pins, 1 = pressed
//   btn_level    out  N_BTN  debounced level, registered
//   btn_press    out  N_BTN  1-cycle pulse on a debounced 0->1 transition (and on each auto-repeat)
//   btn_release  out  N_BTN  1-cycle pulse on a debounced 1->0 transition
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): sync FFs, btn_level, btn_press, btn_release and all counters go to 0.
//   - Synchroniser: two FF stages per channel, s1 <= btn_in; s2 <= s1. Only s2 is used downstream.
//   - Debounce, per channel, with counter cnt and accepted level db (= btn_level):
//       * s2 == db                          -> cnt <= 0; no change.
//       * s2 != db and cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
//       * s2 != db and cnt == DEBOUNCE_CYCLES-1 -> db <= s2; cnt <= 0.
//       * Any glitch back to s2 == db before terminal count restarts cnt from 0.
//       * The counter never wraps.
//   - Latency: a clean input step appears on btn_level exactly 2 + DEBOUNCE_CYCLES clk edges later.
//   - Pulses are registered on the same edge that db changes:
//       * btn_press[i]   = db rising
//       * btn_release[i] = db falling
//       * Each pulse is exactly 1 cycle wide. press and release never assert together on one channel.
//   - Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses.
//   - A button held through reset deassertion: db starts at 0, so a single press fires 2+DEBOUNCE_CYCLES cycles after reset release.
//   - Reset mid-debounce discards the partial count. No pulse is emitted on reset assertion.
//   - DEBOUNCE_CYCLES >= 1 and < 2**CNT_W; the implementation does not need to handle other values.
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     - Each channel with REPEAT_MASK[i]=1 has a hold counter, cleared whenever db=0.
//     - While db=1, the hold counter counts. At HOLD_CYCLES after the initial press it emits an extra btn_press pulse.
//     - After that it emits one every REPEAT_CYCLES until release.
//     - Release clears the hold counter immediately; no pulse fires on the release edge.
//     - btn_release is unaffected.
//   BTN_AUTOREPEAT_EN undefined:
//     - No hold counters are built; REPEAT_MASK, HOLD_CYCLES and REPEAT_CYCLES are ignored.
//     - Exactly one btn_press per debounced rising edge.
// TESTING (bench uses DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5)
//   1. reset=0 with btn_in=4'hF for 5 cycles, then release reset
//        -> all outputs 0 during reset; btn_level=4'hF and a single btn_press=4'hF pulse 10 cycles after release.
//   2. btn_in[1] 0->1 clean step
//        -> btn_level[1] rises on edge 10; btn_press[1] high exactly that one cycle.
//   3. btn_in[2] toggles every 3 cycles for 30 cycles, then holds 1
//        -> no pulse during bouncing; one btn_press[2] 10 cycles after the last toggle.
//   4. btn_in[0] and btn_in[3] released on the same cycle
//        -> btn_release[0] and btn_release[3] pulse together; no press pulses.
//   5. reset pulsed low while btn_in[1] has been stable for 5 cycles of debounce
//        -> cnt cleared; level rises 10 cycles after reset release, not earlier.
//   6. (BTN_AUTOREPEAT_EN) hold btn_in[1] for 60 cycles
//        -> presses at debounce, +20, +25, +30 ... cycles;
//        -> the same hold on btn_in[0] (mask bit 0) gives exactly one press.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel two-stage synchroniser, counter debouncer and
// edge detector for the board push-buttons. btn_level is the accepted level;
// btn_press / btn_release are single-cycle pulses on accepted transitions.
// Optional auto-repeat on held buttons is built when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
   parameter int unsigned           N_BTN           = 4,
   parameter int unsigned           CNT_W           = 20,
   parameter int unsigned           DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned           HOLD_CYCLES     = 50000000,
   parameter int unsigned           REPEAT_CYCLES   = 20000000,
   parameter logic [N_BTN-1:0]      REPEAT_MASK     = 4'b0110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [CNT_W-1:0] cnt [N_BTN];
   logic [N_BTN-1:0] rise_evt;
   logic [N_BTN-1:0] fall_evt;
   logic [N_BTN-1:0] rep_evt;

   // Two-flop synchroniser for the asynchronous pins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   // Accepted-transition detect: the input has differed for the full debounce window
   always_comb begin
      rise_evt = '0;
      fall_evt = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if ((s2[i] != btn_level[i]) && (cnt[i] == DB_TERM)) begin
            rise_evt[i] = s2[i];
            fall_evt[i] = ~s2[i];
         end
      end
   end

   // Debounce counters, accepted level and registered edge pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         btn_press   <= rise_evt | rep_evt;
         btn_release <= fall_evt;
         for (int unsigned i = 0; i < N_BTN; i++) begin
            if (s2[i] == btn_level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_TERM) begin
               btn_level[i] <= s2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   // Hold counter is widened beyond CNT_W when the hold/repeat periods need more bits.
   localparam int unsigned NEED_W = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1;
   localparam int unsigned HOLD_W = (CNT_W > NEED_W) ? CNT_W : NEED_W;
   localparam logic [HOLD_W-1:0] H_TERM = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] R_TERM = HOLD_W'(REPEAT_CYCLES - 1);

   typedef enum logic {PH_HOLD, PH_REPEAT} phase_t;

   for (genvar g = 0; g < N_BTN; g++) begin : g_rep
      if (REPEAT_MASK[g]) begin : g_on
         logic [HOLD_W-1:0] hcnt;
         phase_t            phase;
         logic              hit;

         // Repeat pulse when the held channel reaches the current phase's terminal count
         always_comb begin
            hit = btn_level[g] & ~fall_evt[g] &
                  (hcnt == ((phase == PH_REPEAT) ? R_TERM : H_TERM));
         end

         assign rep_evt[g] = hit;

         // Hold counter: first period HOLD_CYCLES, then REPEAT_CYCLES until release
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               hcnt  <= '0;
               phase <= PH_HOLD;
            end else if (!btn_level[g] || fall_evt[g]) begin
               hcnt  <= '0;
               phase <= PH_HOLD;
            end else if (hit) begin
               hcnt  <= '0;
               phase <= PH_REPEAT;
            end else begin
               hcnt <= hcnt + HOLD_W'(1);
            end
         end
      end else begin : g_off
         assign rep_evt[g] = 1'b0;
      end
   end
`else
   assign rep_evt = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short debounce/hold/repeat periods.
// Reference model: the accepted level flips when the last DEBOUNCE_CYCLES synchronised
// samples all differ from it; repeat presses fall at HOLD + k*REPEAT edges after a press.
module tb_button_conditioner;

   localparam int unsigned NB = 4;
   localparam int          D  = 8;
   localparam int          H  = 20;
   localparam int          R  = 5;
   localparam logic [3:0]  MASK = 4'b0110;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic [3:0] btn_in = 4'h0;
   logic [3:0] lvl;
   logic [3:0] prs;
   logic [3:0] rel;

   button_conditioner #(
      .N_BTN(NB),
      .CNT_W(20),
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES(H),
      .REPEAT_CYCLES(R),
      .REPEAT_MASK(MASK)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_in(btn_in),
      .btn_level(lvl),
      .btn_press(prs),
      .btn_release(rel)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Model state: input history indexed by edge number since reset release
   logic [3:0] hist [0:4095];
   int         t;
   logic [3:0] m_lvl;
   logic [3:0] m_prs;
   logic [3:0] m_rel;
   int         rise_t [4];

   function automatic logic samp(input int e, input int ch);
      // At edge e the debouncer sees the pin value present before edge e-2
      return (e >= 3) ? hist[e-2][ch] : 1'b0;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, t, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [3:0] n_lvl;
      logic [3:0] n_prs;
      logic [3:0] n_rel;
      n_lvl = m_lvl;
      n_prs = '0;
      n_rel = '0;
      for (int ch = 0; ch < 4; ch++) begin
         logic old;
         bit   all_diff;
         old      = m_lvl[ch];
         all_diff = (t >= D);
         for (int j = t - D + 1; j <= t; j++) begin
            if (j >= 1 && samp(j, ch) == old) all_diff = 0;
         end
         if (all_diff) begin
            n_lvl[ch] = ~old;
            if (!old) begin
               n_prs[ch]  = 1'b1;
               rise_t[ch] = t;
            end else begin
               n_rel[ch] = 1'b1;
            end
         end
`ifdef BTN_AUTOREPEAT_EN
         else if (MASK[ch] && old && (t - rise_t[ch]) >= H && ((t - rise_t[ch] - H) % R) == 0) begin
            n_prs[ch] = 1'b1;
         end
`endif
      end
      m_lvl = n_lvl;
      m_prs = n_prs;
      m_rel = n_rel;
   endtask

   task automatic step(input logic [3:0] v);
      btn_in = v;
      @(posedge clk);
      t++;
      hist[t] = v;
      model_edge();
      #1;
      check("level", lvl, m_lvl);
      check("press", prs, m_prs);
      check("release", rel, m_rel);
   endtask

   task automatic apply_reset(input int n, input logic [3:0] v);
      reset  = 1'b0;
      btn_in = v;
      #1;
      check("rst_async_level", lvl, 4'h0);
      check("rst_async_press", prs, 4'h0);
      check("rst_async_release", rel, 4'h0);
      repeat (n) begin
         @(posedge clk);
         #1;
         check("rst_level", lvl, 4'h0);
         check("rst_press", prs, 4'h0);
         check("rst_release", rel, 4'h0);
      end
      reset = 1'b1;
      t     = 0;
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
   endtask

   initial begin
      logic [3:0] v;
      int         remain [4];

      // 1: button held through reset; one press of all channels at edge 10
      btn_in = 4'hF;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("t1_rst_level", lvl, 4'h0);
         check("t1_rst_press", prs, 4'h0);
         check("t1_rst_release", rel, 4'h0);
      end
      reset = 1'b1;
      t     = 0;
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
      for (int k = 1; k <= 12; k++) begin
         step(4'hF);
         if (k == 9)  check("t1_pre_level", lvl, 4'h0);
         if (k == 10) check("t1_level", lvl, 4'hF);
         if (k == 10) check("t1_press", prs, 4'hF);
         if (k == 11) check("t1_press_width", prs, 4'h0);
      end

      // 2: clean step on channel 1
      for (int k = 1; k <= 12; k++) step(4'hD);
      for (int k = 1; k <= 12; k++) begin
         step(4'hF);
         if (k == 9)  check("t2_pre_level", lvl, 4'hD);
         if (k == 10) check("t2_press", prs, 4'b0010);
         if (k == 11) check("t2_press_width", prs, 4'h0);
      end

      // 3: channel 2 bounces every 3 cycles, then settles high
      for (int k = 1; k <= 12; k++) step(4'hB);
      for (int k = 0; k < 30; k++) begin
         step((((k / 3) % 2) == 0) ? 4'hF : 4'hB);
         check("t3_no_pulse", prs | rel, 4'h0);
      end
      for (int k = 1; k <= 14; k++) begin
         step(4'hF);
         if (k == 9)  check("t3_pre_press", prs, 4'h0);
         if (k == 10) check("t3_press", prs, 4'b0100);
      end

      // 4: channels 0 and 3 released together
      for (int k = 1; k <= 12; k++) begin
         step(4'h6);
         if (k == 10) check("t4_release", rel, 4'b1001);
         if (k == 10) check("t4_no_press", prs, 4'h0);
      end

      // 5: reset in the middle of a debounce discards the partial count
      for (int k = 1; k <= 12; k++) step(4'h4);
      for (int k = 1; k <= 7; k++) step(4'h6);
      apply_reset(2, 4'h6);
      for (int k = 1; k <= 12; k++) begin
         step(4'h6);
         if (k == 9)  check("t5_pre_level", lvl, 4'h0);
         if (k == 10) check("t5_level", lvl, 4'h6);
      end

      // Randomised per-channel hold lengths, some shorter than the debounce window
      v = 4'h6;
      for (int ch = 0; ch < 4; ch++) remain[ch] = int'($urandom_range(1, 14));
      for (int k = 0; k < 400; k++) begin
         for (int ch = 0; ch < 4; ch++) begin
            remain[ch]--;
            if (remain[ch] <= 0) begin
               v[ch]      = ~v[ch];
               remain[ch] = int'($urandom_range(1, 14));
            end
         end
         step(v);
      end

`ifdef BTN_AUTOREPEAT_EN
      // 6: long hold on channels 0 and 1; only channel 1 is allowed to repeat
      for (int k = 1; k <= 12; k++) step(4'h0);
      for (int k = 1; k <= 60; k++) begin
         step(4'h3);
         if (k == 10) check("t6_press", prs, 4'b0011);
         if (k == 30) check("t6_rep1", prs, 4'b0010);
         if (k == 35) check("t6_rep2", prs, 4'b0010);
         if (k == 36) check("t6_rep_gap", prs, 4'b0000);
      end
      for (int k = 1; k <= 12; k++) step(4'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
